// File: rtl/crc_pkg.sv
// Shared definitions for the CRC datapath: reflection mode codes and the
// state encoding of the byte-serial reflector.
package crc_pkg;

  localparam logic [1:0] REFL_PASS = 2'b00;
  localparam logic [1:0] REFL_BYTE = 2'b01;
  localparam logic [1:0] REFL_SWAP = 2'b10;
  localparam logic [1:0] REFL_FULL = 2'b11;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/reflect8.sv
// 8-bit bit reversal: output bit k is input bit 7-k.
module reflect8 (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  for (genvar k = 0; k < 8; k++) begin : g_bit
    assign o_byte[k] = i_byte[7-k];
  end

endmodule

// File: rtl/reflect_stream.sv
// Byte-serial reflection engine: collects a word of up to MAX_BYTES bytes,
// transforms it, then returns it as a parallel value and a byte stream.
module reflect_stream
  import crc_pkg::*;
#(
  parameter  int MAX_BYTES = 8,
  localparam int CW        = $clog2(MAX_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [8*MAX_BYTES-1:0] result_value,
  output logic [CW-1:0]          result_len,
  output logic                   result_valid
);

  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BYTES - 1);
  localparam logic [CW-1:0] ZERO_IDX = {CW{1'b0}};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          r_oidx;
  logic [CW-1:0]          r_len;
  logic [CW-1:0]          w_oidx_inc;
  logic [1:0]             r_mode;
  logic [1:0]             w_mode_eff;
  logic [7:0]             r_bytes      [MAX_BYTES];
  logic [7:0]             w_next_bytes [MAX_BYTES];
  logic [8*MAX_BYTES-1:0] r_result;
  logic [8*MAX_BYTES-1:0] w_result;
  logic [7:0]             r_out_data;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic                   r_result_valid;
  logic                   w_swap;
  logic                   w_refl;
  logic                   w_accept;
  logic                   w_last_byte;
  logic                   w_emit_adv;
  logic                   w_emit_done;

  assign w_accept    = (r_state == ST_COLLECT) && in_valid;
  assign w_last_byte = w_accept && (in_last || (r_cnt == LAST_IDX));
  assign w_emit_adv  = (r_state == ST_EMIT) && out_ready;
  assign w_emit_done = w_emit_adv && (r_oidx == r_len);
  assign w_oidx_inc  = r_oidx + CW'(1);
  // The mode travels with the first byte, so it is taken live while cnt is 0.
  assign w_mode_eff  = (r_cnt == ZERO_IDX) ? mode : r_mode;

  always_comb begin
    w_swap = 1'b0;
    w_refl = 1'b0;
    case (w_mode_eff)
      REFL_PASS: begin w_swap = 1'b0; w_refl = 1'b0; end
      REFL_BYTE: begin w_swap = 1'b0; w_refl = 1'b1; end
      REFL_SWAP: begin w_swap = 1'b1; w_refl = 1'b0; end
      REFL_FULL: begin w_swap = 1'b1; w_refl = 1'b1; end
      default:   begin w_swap = 1'b0; w_refl = 1'b0; end
    endcase
  end

  // Result is built from stored bytes plus the byte being accepted this cycle.
  for (genvar g = 0; g < MAX_BYTES; g++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(g);
    logic [CW-1:0] w_src_idx;
    logic [7:0]    w_lane;
    logic [7:0]    w_lane_rev;

    assign w_next_bytes[g] = (r_cnt == LANE) ? in_data : r_bytes[g];
    assign w_src_idx       = w_swap ? (r_cnt - LANE) : LANE;
    assign w_lane          = (LANE <= r_cnt) ? w_next_bytes[w_src_idx] : 8'h00;

    reflect8 u_reflect8 (
      .i_byte (w_lane),
      .o_byte (w_lane_rev)
    );

    assign w_result[8*g +: 8] = w_refl ? w_lane_rev : w_lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: begin
        if (w_last_byte) w_state_nxt = ST_EMIT;
        else             w_state_nxt = ST_COLLECT;
      end
      ST_EMIT: begin
        if (w_emit_done) w_state_nxt = ST_COLLECT;
        else             w_state_nxt = ST_EMIT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= ZERO_IDX;
      r_oidx         <= ZERO_IDX;
      r_len          <= ZERO_IDX;
      r_mode         <= REFL_PASS;
      r_result       <= '0;
      r_out_data     <= 8'h00;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_result_valid <= 1'b0;
      for (int k = 0; k < MAX_BYTES; k++) r_bytes[k] <= 8'h00;
    end else begin
      r_result_valid <= w_last_byte;
      if (w_accept) begin
        r_bytes[r_cnt] <= in_data;
        if (r_cnt == ZERO_IDX) r_mode <= mode;
      end
      if (w_last_byte) begin
        r_cnt       <= ZERO_IDX;
        r_len       <= r_cnt;
        r_result    <= w_result;
        r_oidx      <= ZERO_IDX;
        r_out_valid <= 1'b1;
        r_out_data  <= w_result[7:0];
        r_out_last  <= (r_cnt == ZERO_IDX);
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_emit_done) begin
        r_out_valid <= 1'b0;
        r_out_data  <= 8'h00;
        r_out_last  <= 1'b0;
      end else if (w_emit_adv) begin
        r_oidx     <= w_oidx_inc;
        r_out_data <= r_result[{w_oidx_inc, 3'b000} +: 8];
        r_out_last <= (w_oidx_inc == r_len);
      end
    end
  end

  assign in_ready     = (r_state == ST_COLLECT);
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign result_value = r_result;
  assign result_len   = r_len;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_reflect_stream.sv
// Directed self-checking bench for reflect_stream: expected output bytes are
// queued as each word is sent and popped as the DUT streams them out.
module tb_reflect_stream;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [63:0] result_value;
  logic [2:0]  result_len;
  logic        result_valid;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];

  reflect_stream #(.MAX_BYTES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .result_value (result_value),
    .result_len   (result_len),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sends n bytes of w; mode is scrambled after byte 0 to exercise the latch.
  task automatic send_word(input logic [1:0] m, input logic [127:0] w, input int n,
                           input bit mark_last, input logic [63:0] exp_val);
    for (int i = 0; i < n; i++) begin
      mode     = (i == 0) ? m : ~m;
      in_data  = w[8*i +: 8];
      in_last  = mark_last && (i == n - 1);
      in_valid = 1'b1;
      chk("in_ready_collect", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("result_valid_pulse", result_valid, 1'b1);
    chk("result_value", result_value, exp_val);
    chk("result_len", result_len, n - 1);
    chk("in_ready_after_last", in_ready, 1'b0);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_val[8*i +: 8]);
  endtask

  // Drains the output stream, holding out_ready low for stall_len cycles at byte stall_at.
  task automatic drain(input int stall_at, input int stall_len);
    int idx   = 0;
    int stall = 0;
    int guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      guard++;
      out_ready = !(idx == stall_at && stall < stall_len);
      chk("out_valid", out_valid, 1'b1);
      chk("out_data", out_data, exp_q[0]);
      chk("out_last", out_last, exp_q.size() == 1);
      chk("in_ready_emit", in_ready, 1'b0);
      @(posedge clk); #1;
      if (out_ready) begin
        void'(exp_q.pop_front());
        idx++;
      end else begin
        stall++;
      end
    end
    out_ready = 1'b1;
    chk("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    chk("in_ready_idle", in_ready, 1'b1);
    chk("out_valid_idle", out_valid, 1'b0);
    chk("result_valid_one_cycle", result_valid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 2'b00;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_result_value", result_value, 64'h0);
    chk("rst_result_len", result_len, 3'd0);
    chk("rst_result_valid", result_valid, 1'b0);

    send_word(2'b11, 128'h0201, 2, 1'b1, 64'h8040);
    drain(-1, 0);
    send_word(2'b01, 128'h0201, 2, 1'b1, 64'h4080);
    drain(-1, 0);
    send_word(2'b10, 128'h3412, 2, 1'b1, 64'h1234);
    drain(-1, 0);
    send_word(2'b00, 128'hA5, 1, 1'b1, 64'hA5);
    drain(-1, 0);
    send_word(2'b11, 128'h0807060504030201, 8, 1'b0, 64'h8040C020A060E010);
    drain(-1, 0);
    send_word(2'b10, 128'hCCBBAA, 3, 1'b1, 64'hAABBCC);
    drain(-1, 0);
    send_word(2'b00, 128'h44332211, 4, 1'b1, 64'h44332211);
    drain(1, 3);

    send_word(2'b11, 128'h04030201, 4, 1'b1, 64'h8040C020);
    chk("pre_rst_byte0", out_data, 8'h20);
    @(posedge clk); #1;
    chk("pre_rst_byte1", out_data, 8'hC0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 8'h00);
    chk("midrst_out_last", out_last, 1'b0);
    chk("midrst_result_value", result_value, 64'h0);
    chk("midrst_result_len", result_len, 3'd0);
    #2 rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("postrst_in_ready", in_ready, 1'b1);
    send_word(2'b01, 128'h0201, 2, 1'b1, 64'h4080);
    drain(-1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
